fdc_sector_buffer: RTL and testbench

- Sector staging buffer that sits directly downstream of the nec765 FDC core, between its sector-transfer side and the host/MCU disk-image link.
- The FDC requests one sector by (unit, side, track, sector, size code). The block asks the host to fill or drain an internal RAM, then serves or collects the bytes one at a time on FDC strobes.
- Host link follows the codebase's status-word / control-word / strobed-byte convention.

---
 rtl/fdc_sector_buffer_pkg.sv | 31 +++
 rtl/fdc_sector_buffer_if.sv | 39 +++
 rtl/fdc_sector_buffer_ram.sv | 20 ++
 rtl/fdc_sector_buffer.sv | 201 ++++++++++++++++++++
 tb/tb_fdc_sector_buffer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fdc_sector_buffer_pkg.sv
// Shared definitions for the FDC sector staging buffer: state encoding,
// host status/control word layout and size-code decoding.
package fdc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOST_FILL,
        ST_FDC_READ,
        ST_FDC_WRITE,
        ST_HOST_DRAIN
    } fdc_state_e;

    localparam int PTR_W = 11;

    // host_sr layout, low bits carry byte_ptr[PTR_W-1:0]
    localparam int SR_PENDING    = 31;
    localparam int SR_WRITE      = 30;
    localparam int SR_UNIT       = 29;
    localparam int SR_SIDE       = 28;
    localparam int SR_TRACK_LSB  = 21;
    localparam int SR_SECTOR_LSB = 13;
    localparam int SR_N_LSB      = 11;

    localparam int CR_DONE  = 31;
    localparam int CR_ERROR = 30;

    function automatic logic [PTR_W-1:0] n_to_len(input logic [2:0] n);
        return 11'd128 << n;
    endfunction

endpackage

// File: rtl/fdc_sector_buffer_if.sv
// FDC request/byte handshake plus host status/control/byte link.
interface fdc_sector_buffer_if;
    logic        req;
    logic        req_write;
    logic        req_unit;
    logic        req_side;
    logic [6:0]  req_track;
    logic [7:0]  req_sector;
    logic [2:0]  req_n;
    logic        abort;
    logic        rd_strobe;
    logic [7:0]  rd_data;
    logic        wr_strobe;
    logic [7:0]  wr_data;
    logic        sec_ready;
    logic        xfer_done;
    logic        sec_err;
    logic        busy;
    logic [31:0] host_sr;
    logic [31:0] host_cr;
    logic [7:0]  host_data_in;
    logic        host_data_clkin;
    logic [7:0]  host_data_out;
    logic        host_data_clkout;

    modport master (
        output req, req_write, req_unit, req_side, req_track, req_sector, req_n,
        output abort, rd_strobe, wr_strobe, wr_data,
        output host_cr, host_data_in, host_data_clkin, host_data_clkout,
        input  rd_data, sec_ready, xfer_done, sec_err, busy, host_sr, host_data_out
    );

    modport slave (
        input  req, req_write, req_unit, req_side, req_track, req_sector, req_n,
        input  abort, rd_strobe, wr_strobe, wr_data,
        input  host_cr, host_data_in, host_data_clkin, host_data_clkout,
        output rd_data, sec_ready, xfer_done, sec_err, busy, host_sr, host_data_out
    );
endinterface

// File: rtl/fdc_sector_buffer_ram.sv
// Single-port sector RAM, synchronous write and registered read.
module fdc_sector_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);
    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end
endmodule

// File: rtl/fdc_sector_buffer.sv
// Sector staging buffer between the FDC byte interface and the host image link.
//   state         | meaning
//   ST_IDLE       | waiting for req
//   ST_HOST_FILL  | host loads sector for an FDC read
//   ST_FDC_READ   | FDC pulls bytes with rd_strobe
//   ST_FDC_WRITE  | FDC pushes bytes with wr_strobe
//   ST_HOST_DRAIN | host fetches written sector
module fdc_sector_buffer
    import fdc_pkg::*;
#(
    parameter int MAX_N  = 3,
    parameter int ADDR_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    fdc_sector_buffer_if.slave bus
);
    localparam logic [2:0] MAX_N_L = 3'(MAX_N);

    fdc_state_e        state;
    logic [PTR_W-1:0]  ptr, len, ptr_inc;
    logic              lat_write, lat_unit, lat_side, pending;
    logic [6:0]        lat_track;
    logic [7:0]        lat_sector;
    logic [1:0]        lat_n;
    logic              done_q, err_q, done_rise, err_rise, host_phase, host_err_act;
    logic              rd_load_q, rd_src_q, rd_last_q, drain_load_q;
    logic [7:0]        rd_data_q, hout_q, ram_q, ram_wdata;
    logic              sec_ready_q, xfer_done_q, sec_err_q;
    logic              ram_en, ram_we;
    logic [31:0]       sr;
    logic              unused_cr;

    assign done_rise    = bus.host_cr[CR_DONE] & ~done_q;
    assign err_rise     = bus.host_cr[CR_ERROR] & ~err_q;
    assign host_phase   = (state == ST_HOST_FILL) || (state == ST_HOST_DRAIN);
    assign host_err_act = host_phase & err_rise;
    assign ptr_inc      = ptr + {{(PTR_W-1){1'b0}}, ram_en};
    assign unused_cr    = ^bus.host_cr[29:0];

    // The RAM port doubles as the "byte accepted" signal for pointer advance.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = bus.host_data_in;
        if (!bus.abort && !host_err_act) begin
            case (state)
                ST_HOST_FILL: begin
                    ram_en = bus.host_data_clkin && (ptr != len);
                    ram_we = 1'b1;
                end
                ST_FDC_READ:  ram_en = bus.rd_strobe;
                ST_FDC_WRITE: begin
                    ram_en    = bus.wr_strobe;
                    ram_we    = 1'b1;
                    ram_wdata = bus.wr_data;
                end
                ST_HOST_DRAIN: ram_en = bus.host_data_clkout && (ptr != len) && !done_rise;
                default: ram_en = 1'b0;
            endcase
        end
    end

    fdc_sector_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ptr[ADDR_W-1:0]),
        .wdata (ram_wdata),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            len          <= '0;
            lat_write    <= 1'b0;
            lat_unit     <= 1'b0;
            lat_side     <= 1'b0;
            lat_track    <= '0;
            lat_sector   <= '0;
            lat_n        <= '0;
            pending      <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            rd_load_q    <= 1'b0;
            rd_src_q     <= 1'b0;
            rd_last_q    <= 1'b0;
            drain_load_q <= 1'b0;
            rd_data_q    <= 8'hFF;
            hout_q       <= 8'h00;
            sec_ready_q  <= 1'b0;
            xfer_done_q  <= 1'b0;
            sec_err_q    <= 1'b0;
        end else begin
            done_q       <= bus.host_cr[CR_DONE];
            err_q        <= bus.host_cr[CR_ERROR];
            sec_ready_q  <= 1'b0;
            sec_err_q    <= 1'b0;
            xfer_done_q  <= rd_last_q;
            rd_last_q    <= 1'b0;
            drain_load_q <= 1'b0;
            // FDC read data lands one cycle after the RAM access; strobes outside a read give 0xFF
            rd_load_q    <= bus.rd_strobe;
            rd_src_q     <= (state == ST_FDC_READ) && !bus.abort;
            if (rd_load_q)    rd_data_q <= rd_src_q ? ram_q : 8'hFF;
            if (drain_load_q) hout_q    <= ram_q;
            ptr <= ptr_inc;

            if (bus.abort) begin
                state   <= ST_IDLE;
                pending <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: if (bus.req) begin
                        ptr <= '0;
                        if (bus.req_n > MAX_N_L) begin
                            sec_err_q <= 1'b1;
                        end else begin
                            len        <= n_to_len(bus.req_n);
                            lat_write  <= bus.req_write;
                            lat_unit   <= bus.req_unit;
                            lat_side   <= bus.req_side;
                            lat_track  <= bus.req_track;
                            lat_sector <= bus.req_sector;
                            lat_n      <= bus.req_n[1:0];
                            if (bus.req_write) begin
                                state       <= ST_FDC_WRITE;
                                sec_ready_q <= 1'b1;
                            end else begin
                                state   <= ST_HOST_FILL;
                                pending <= 1'b1;
                            end
                        end
                    end
                    ST_HOST_FILL: begin
                        if (err_rise) begin
                            sec_err_q <= 1'b1;
                            state     <= ST_IDLE;
                            pending   <= 1'b0;
                        end else if (done_rise) begin
                            pending <= 1'b0;
                            if (ptr_inc == len) begin
                                state       <= ST_FDC_READ;
                                ptr         <= '0;
                                sec_ready_q <= 1'b1;
                            end else begin
                                state     <= ST_IDLE;
                                sec_err_q <= 1'b1;
                            end
                        end
                    end
                    ST_FDC_READ: if (bus.rd_strobe && ptr == len - 1'b1) begin
                        rd_last_q <= 1'b1;
                        state     <= ST_IDLE;
                    end
                    ST_FDC_WRITE: if (bus.wr_strobe && ptr == len - 1'b1) begin
                        state   <= ST_HOST_DRAIN;
                        ptr     <= '0;
                        pending <= 1'b1;
                    end
                    ST_HOST_DRAIN: begin
                        if (err_rise) begin
                            sec_err_q <= 1'b1;
                            state     <= ST_IDLE;
                            pending   <= 1'b0;
                        end else if (done_rise) begin
                            xfer_done_q <= 1'b1;
                            state       <= ST_IDLE;
                            pending     <= 1'b0;
                        end else begin
                            drain_load_q <= ram_en;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        sr                         = '0;
        sr[SR_PENDING]             = pending;
        sr[SR_WRITE]               = lat_write;
        sr[SR_UNIT]                = lat_unit;
        sr[SR_SIDE]                = lat_side;
        sr[SR_TRACK_LSB +: 7]      = lat_track;
        sr[SR_SECTOR_LSB +: 8]     = lat_sector;
        sr[SR_N_LSB +: 2]          = lat_n;
        sr[PTR_W-1:0]              = ptr;
    end

    assign bus.host_sr       = sr;
    assign bus.rd_data       = rd_data_q;
    assign bus.host_data_out = hout_q;
    assign bus.sec_ready     = sec_ready_q;
    assign bus.xfer_done     = xfer_done_q;
    assign bus.sec_err       = sec_err_q;
    assign bus.busy          = (state != ST_IDLE);
endmodule

// File: tb/tb_fdc_sector_buffer.sv
// Directed bench for fdc_sector_buffer: read, write, short fill, errors, abort, reset.
module tb_fdc_sector_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    fdc_sector_buffer_if bus();

    fdc_sector_buffer #(.MAX_N(3), .ADDR_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic wr, input logic unit, input logic side,
                             input logic [6:0] track, input logic [7:0] sec, input logic [2:0] n);
        bus.req_write  = wr;
        bus.req_unit   = unit;
        bus.req_side   = side;
        bus.req_track  = track;
        bus.req_sector = sec;
        bus.req_n      = n;
        bus.req        = 1'b1;
        tick();
        bus.req = 1'b0;
    endtask

    task automatic fill(input int count, input logic [7:0] xor_v);
        for (int i = 0; i < count; i++) begin
            bus.host_data_in    = 8'(i) ^ xor_v;
            bus.host_data_clkin = 1'b1;
            tick();
        end
        bus.host_data_clkin = 1'b0;
    endtask

    task automatic pulse_done();
        bus.host_cr[31] = 1'b1;
        tick();
        bus.host_cr[31] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        total++; if (bus.rd_data !== 8'hFF) begin bad++; $display("FAIL reset_rd_data: got %h expected ff", bus.rd_data); end
        total++; if (bus.host_data_out !== 8'h00) begin bad++; $display("FAIL reset_hout: got %h expected 00", bus.host_data_out); end
        total++; if (bus.host_sr !== 32'h0) begin bad++; $display("FAIL reset_sr: got %h expected 0", bus.host_sr); end
        total++; if ({bus.sec_ready, bus.xfer_done, bus.sec_err} !== 3'b000) begin bad++; $display("FAIL reset_pulses: got %b expected 000", {bus.sec_ready, bus.xfer_done, bus.sec_err}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read();
        start_req(1'b0, 1'b0, 1'b0, 7'd5, 8'hC1, 3'd2);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL read_busy: got %b expected 1", bus.busy); end
        total++; if (bus.host_sr !== 32'h80B83000) begin bad++; $display("FAIL read_sr_fill: got %h expected 80b83000", bus.host_sr); end
        fill(512, 8'h00);
        total++; if (bus.host_sr[10:0] !== 11'd512) begin bad++; $display("FAIL read_fill_ptr: got %0d expected 512", bus.host_sr[10:0]); end
        pulse_done();
        total++; if (bus.sec_ready !== 1'b1) begin bad++; $display("FAIL read_sec_ready: got %b expected 1", bus.sec_ready); end
        total++; if (bus.host_sr !== 32'h00B83000) begin bad++; $display("FAIL read_sr_fdc: got %h expected 00b83000", bus.host_sr); end
        tick();
        total++; if (bus.sec_ready !== 1'b0) begin bad++; $display("FAIL read_sec_ready_drop: got %b expected 0", bus.sec_ready); end
        for (int i = 0; i < 512; i++) begin
            logic [7:0] exp_b;
            exp_b = 8'(i);
            bus.rd_strobe = 1'b1;
            tick();
            bus.rd_strobe = 1'b0;
            tick();
            total++; if (bus.rd_data !== exp_b) begin bad++; $display("FAIL read_byte_%0d: got %h expected %h", i, bus.rd_data, exp_b); end
            total++; if (bus.xfer_done !== (i == 511)) begin bad++; $display("FAIL read_xfer_done_%0d: got %b expected %b", i, bus.xfer_done, (i == 511)); end
        end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL read_busy_end: got %b expected 0", bus.busy); end
        tick();
        total++; if (bus.xfer_done !== 1'b0) begin bad++; $display("FAIL read_xfer_done_drop: got %b expected 0", bus.xfer_done); end
    endtask

    task automatic test_write();
        start_req(1'b1, 1'b1, 1'b1, 7'd10, 8'h03, 3'd1);
        total++; if (bus.sec_ready !== 1'b1) begin bad++; $display("FAIL write_sec_ready: got %b expected 1", bus.sec_ready); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL write_busy: got %b expected 1", bus.busy); end
        for (int i = 0; i < 256; i++) begin
            bus.wr_data   = ~8'(i);
            bus.wr_strobe = 1'b1;
            tick();
        end
        bus.wr_strobe = 1'b0;
        total++; if (bus.host_sr !== 32'hF1406800) begin bad++; $display("FAIL write_sr_drain: got %h expected f1406800", bus.host_sr); end
        for (int i = 0; i < 256; i++) begin
            logic [7:0] exp_b;
            exp_b = ~8'(i);
            bus.host_data_clkout = 1'b1;
            tick();
            bus.host_data_clkout = 1'b0;
            tick();
            total++; if (bus.host_data_out !== exp_b) begin bad++; $display("FAIL drain_byte_%0d: got %h expected %h", i, bus.host_data_out, exp_b); end
        end
        bus.host_data_clkout = 1'b1;
        tick();
        bus.host_data_clkout = 1'b0;
        tick();
        total++; if (bus.host_sr[10:0] !== 11'd256) begin bad++; $display("FAIL drain_ptr_sat: got %0d expected 256", bus.host_sr[10:0]); end
        total++; if (bus.host_data_out !== 8'h00) begin bad++; $display("FAIL drain_sat_data: got %h expected 00", bus.host_data_out); end
        pulse_done();
        total++; if (bus.xfer_done !== 1'b1) begin bad++; $display("FAIL write_xfer_done: got %b expected 1", bus.xfer_done); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL write_busy_end: got %b expected 0", bus.busy); end
        total++; if (bus.host_sr[31] !== 1'b0) begin bad++; $display("FAIL write_pending_end: got %b expected 0", bus.host_sr[31]); end
        tick();
    endtask

    task automatic test_short_fill();
        start_req(1'b0, 1'b0, 1'b1, 7'd2, 8'h07, 3'd2);
        fill(100, 8'h00);
        pulse_done();
        total++; if (bus.sec_err !== 1'b1) begin bad++; $display("FAIL short_sec_err: got %b expected 1", bus.sec_err); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL short_busy: got %b expected 0", bus.busy); end
        total++; if (bus.host_sr[31] !== 1'b0) begin bad++; $display("FAIL short_pending: got %b expected 0", bus.host_sr[31]); end
        total++; if (bus.sec_ready !== 1'b0) begin bad++; $display("FAIL short_sec_ready: got %b expected 0", bus.sec_ready); end
        tick();
        total++; if (bus.sec_err !== 1'b0) begin bad++; $display("FAIL short_sec_err_drop: got %b expected 0", bus.sec_err); end
    endtask

    task automatic test_errors();
        start_req(1'b0, 1'b0, 1'b0, 7'd1, 8'h01, 3'd0);
        fill(10, 8'h00);
        bus.host_cr[30] = 1'b1;
        tick();
        bus.host_cr[30] = 1'b0;
        total++; if (bus.sec_err !== 1'b1) begin bad++; $display("FAIL herr_sec_err: got %b expected 1", bus.sec_err); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL herr_busy: got %b expected 0", bus.busy); end
        tick();
        start_req(1'b0, 1'b0, 1'b0, 7'd1, 8'h01, 3'd4);
        total++; if (bus.sec_err !== 1'b1) begin bad++; $display("FAIL badn_sec_err: got %b expected 1", bus.sec_err); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL badn_busy: got %b expected 0", bus.busy); end
        tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL badn_busy_later: got %b expected 0", bus.busy); end
        total++; if (bus.sec_err !== 1'b0) begin bad++; $display("FAIL badn_sec_err_drop: got %b expected 0", bus.sec_err); end
    endtask

    task automatic test_abort();
        start_req(1'b0, 1'b0, 1'b0, 7'd3, 8'h10, 3'd0);
        fill(128, 8'h5A);
        pulse_done();
        total++; if (bus.sec_ready !== 1'b1) begin bad++; $display("FAIL abort_sec_ready: got %b expected 1", bus.sec_ready); end
        for (int i = 0; i < 37; i++) begin
            logic [7:0] exp_b;
            exp_b = 8'(i) ^ 8'h5A;
            bus.rd_strobe = 1'b1;
            tick();
            bus.rd_strobe = 1'b0;
            tick();
            total++; if (bus.rd_data !== exp_b) begin bad++; $display("FAIL abort_read_%0d: got %h expected %h", i, bus.rd_data, exp_b); end
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
        total++; if ({bus.xfer_done, bus.sec_err} !== 2'b00) begin bad++; $display("FAIL abort_pulses: got %b expected 00", {bus.xfer_done, bus.sec_err}); end
        bus.rd_strobe = 1'b1;
        tick();
        bus.rd_strobe = 1'b0;
        tick();
        total++; if (bus.rd_data !== 8'hFF) begin bad++; $display("FAIL abort_rd_ff: got %h expected ff", bus.rd_data); end
        start_req(1'b1, 1'b0, 1'b0, 7'd3, 8'h10, 3'd0);
        total++; if (bus.sec_ready !== 1'b1) begin bad++; $display("FAIL abort_new_req: got %b expected 1", bus.sec_ready); end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy2: got %b expected 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        start_req(1'b1, 1'b0, 1'b0, 7'd20, 8'h02, 3'd0);
        for (int i = 0; i < 128; i++) begin
            bus.wr_data   = 8'(i) | 8'h80;
            bus.wr_strobe = 1'b1;
            tick();
        end
        bus.wr_strobe = 1'b0;
        total++; if (bus.host_sr[31] !== 1'b1) begin bad++; $display("FAIL rstmid_pending: got %b expected 1", bus.host_sr[31]); end
        for (int i = 0; i < 2; i++) begin
            bus.host_data_clkout = 1'b1;
            tick();
            bus.host_data_clkout = 1'b0;
            tick();
        end
        total++; if (bus.host_data_out !== 8'h81) begin bad++; $display("FAIL rstmid_hout: got %h expected 81", bus.host_data_out); end
        bus.host_cr[31] = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
        total++; if (bus.host_sr !== 32'h0) begin bad++; $display("FAIL rstmid_sr: got %h expected 0", bus.host_sr); end
        total++; if (bus.host_data_out !== 8'h00) begin bad++; $display("FAIL rstmid_hout0: got %h expected 00", bus.host_data_out); end
        total++; if (bus.rd_data !== 8'hFF) begin bad++; $display("FAIL rstmid_rd: got %h expected ff", bus.rd_data); end
        total++; if ({bus.sec_ready, bus.xfer_done, bus.sec_err} !== 3'b000) begin bad++; $display("FAIL rstmid_pulses: got %b expected 000", {bus.sec_ready, bus.xfer_done, bus.sec_err}); end
        tick();
        tick();
        total++; if ({bus.busy, bus.xfer_done, bus.sec_err} !== 3'b000) begin bad++; $display("FAIL rstmid_held_done: got %b expected 000", {bus.busy, bus.xfer_done, bus.sec_err}); end
        start_req(1'b0, 1'b0, 1'b0, 7'd1, 8'h01, 3'd0);
        fill(127, 8'h00);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rstmid_fill_busy: got %b expected 1", bus.busy); end
        total++; if (bus.host_sr[10:0] !== 11'd127) begin bad++; $display("FAIL rstmid_fill_ptr: got %0d expected 127", bus.host_sr[10:0]); end
        bus.host_cr[31] = 1'b0;
        tick();
        bus.host_data_in    = 8'h7F;
        bus.host_data_clkin = 1'b1;
        bus.host_cr[31]     = 1'b1;
        tick();
        bus.host_data_clkin = 1'b0;
        bus.host_cr[31]     = 1'b0;
        total++; if (bus.sec_ready !== 1'b1) begin bad++; $display("FAIL same_cycle_done: got %b expected 1", bus.sec_ready); end
        total++; if (bus.sec_err !== 1'b0) begin bad++; $display("FAIL same_cycle_err: got %b expected 0", bus.sec_err); end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req              = 1'b0;
        bus.req_write        = 1'b0;
        bus.req_unit         = 1'b0;
        bus.req_side         = 1'b0;
        bus.req_track        = '0;
        bus.req_sector       = '0;
        bus.req_n            = '0;
        bus.abort            = 1'b0;
        bus.rd_strobe        = 1'b0;
        bus.wr_strobe        = 1'b0;
        bus.wr_data          = '0;
        bus.host_cr          = '0;
        bus.host_data_in     = '0;
        bus.host_data_clkin  = 1'b0;
        bus.host_data_clkout = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_short_fill();
        test_errors();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
